// File: rtl/cam_pixel_decimator.sv
// Camera decimator: averages DEC_X pixels per group, keeps 1 line in DEC_Y, and queues the results for a valid/ready stream.
// Latency: 2 cycles from the last pixel of a group on cam_data to pix_valid/pix_data.
// Backpressure: the FIFO absorbs stalls; a push into a full FIFO with no same-cycle pop is dropped and sets overflow.
module cam_pixel_decimator #(
    parameter int DEC_X      = 4,
    parameter int DEC_Y      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cam_data,
    input  logic       cam_href,
    input  logic       cam_vsync,
    output logic [7:0] pix_data,
    output logic       pix_sof,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       overflow,
    output logic [7:0] frame_count
);

    localparam int XS   = $clog2(DEC_X);
    localparam int CW   = (XS > 0) ? XS : 1;
    localparam int AW   = 8 + XS;
    localparam int YS   = $clog2(DEC_Y);
    localparam int RW   = (YS > 0) ? YS : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    localparam logic [CW-1:0]   COL_LAST = CW'(DEC_X - 1);
    localparam logic [RW-1:0]   ROW_LAST = RW'(DEC_Y - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        VBLANK,
        ACTIVE
    } state_t;

    // Input capture stage
    logic [7:0] d_q;
    logic       h_q;
    logic       h_qq;
    logic       v_q;
    logic       v_qq;
    logic       v_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q  <= '0;
            h_q  <= 1'b0;
            h_qq <= 1'b0;
            v_q  <= 1'b0;
            v_qq <= 1'b0;
        end else begin
            d_q  <= cam_data;
            h_q  <= cam_href;
            h_qq <= h_q;
            v_q  <= cam_vsync;
            v_qq <= v_q;
        end
    end

    assign v_rise = v_q & ~v_qq;

    // Decimation state
    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [RW-1:0]   row_q, row_d;
    logic            sof_pend_q, sof_pend_d;
    logic [AW-1:0]   grp_sum;
    logic [7:0]      push_dat;
    logic            push;
    logic            frame_start;

    // FIFO state
    logic [8:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_nxt;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_after_pop;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;

    assign grp_sum  = acc_q + AW'(d_q);
    assign push_dat = grp_sum[XS +: 8];

    assign full    = (cnt == CNT_FULL);
    assign pop     = pix_valid & pix_ready;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        acc_d       = acc_q;
        row_d       = row_q;
        sof_pend_d  = sof_pend_q;
        push        = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            WAIT_SYNC: begin
                if (v_rise) begin
                    state_d     = VBLANK;
                    frame_start = 1'b1;
                end
            end
            VBLANK: begin
                col_d      = '0;
                acc_d      = '0;
                row_d      = '0;
                sof_pend_d = 1'b1;
                if (!v_q) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (v_rise) begin
                    // A new frame wins over any group still being built.
                    state_d     = VBLANK;
                    frame_start = 1'b1;
                    col_d       = '0;
                    acc_d       = '0;
                end else if (h_q) begin
                    if (row_q == '0) begin
                        if (col_q == COL_LAST) begin
                            push  = 1'b1;
                            col_d = '0;
                            acc_d = '0;
                        end else begin
                            col_d = col_q + 1'b1;
                            acc_d = grp_sum;
                        end
                    end
                end else begin
                    col_d = '0;
                    acc_d = '0;
                    if (h_qq) begin
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end
                end
            end
            default: state_d = WAIT_SYNC;
        endcase
        // sof sticks with the frame until a push actually lands in the FIFO.
        if (push_ok) begin
            sof_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_SYNC;
            col_q       <= '0;
            acc_q       <= '0;
            row_q       <= '0;
            sof_pend_q  <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            acc_q      <= acc_d;
            row_q      <= row_d;
            sof_pend_q <= sof_pend_d;
            if (frame_start) begin
                overflow    <= 1'b0;
                frame_count <= frame_count + 8'd1;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; entries are never read before they are written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {sof_pend_q, push_dat};
        end
    end

    assign rd_nxt        = pop ? rd_ptr + 1'b1 : rd_ptr;
    assign cnt_after_pop = pop ? cnt - 1'b1 : cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_sof   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_nxt;
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // Head register sees the post-pop FIFO; a same-cycle push shows up one cycle later.
            pix_valid <= (cnt_after_pop != '0);
            if (cnt_after_pop != '0) begin
                pix_data <= mem[rd_nxt][7:0];
                pix_sof  <= mem[rd_nxt][8];
            end
        end
    end

endmodule

// File: tb/tb_cam_pixel_decimator.sv
// Directed bench for cam_pixel_decimator with DEC_X=4, DEC_Y=4, FIFO_DEPTH=8.
module tb_cam_pixel_decimator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cam_data;
    logic       cam_href;
    logic       cam_vsync;
    logic [7:0] pix_data;
    logic       pix_sof;
    logic       pix_valid;
    logic       pix_ready;
    logic       overflow;
    logic [7:0] frame_count;

    int         total = 0;
    int         bad   = 0;
    logic [8:0] rxq[$];

    always #5 clk = ~clk;

    cam_pixel_decimator #(
        .DEC_X      (4),
        .DEC_Y      (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cam_data    (cam_data),
        .cam_href    (cam_href),
        .cam_vsync   (cam_vsync),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    // Record every head accepted at the following rising edge.
    always @(negedge clk) begin
        #2;
        if (pix_valid && pix_ready) begin
            rxq.push_back({pix_sof, pix_data});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic px(input logic [7:0] v);
        cam_data = v;
        cam_href = 1'b1;
        @(negedge clk);
    endtask

    task automatic line_end();
        cam_href = 1'b0;
        cyc(2);
    endtask

    task automatic vsync_pulse();
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        cyc(3);
        cam_vsync = 1'b0;
        cyc(3);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int sof, input int v);
        return 32'(sof * 256 + v);
    endfunction

    initial begin
        rst_n     = 1'b0;
        cam_data  = 8'd0;
        cam_href  = 1'b0;
        cam_vsync = 1'b0;
        pix_ready = 1'b0;
        cyc(3);
        chk("rst_valid", 32'(pix_valid), 0);
        chk("rst_data", 32'(pix_data), 0);
        chk("rst_sof", 32'(pix_sof), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_fc", 32'(frame_count), 0);
        rst_n = 1'b1;
        cyc(2);

        // 1: one 8-pixel line, latency check on the first group
        pix_ready = 1'b1;
        vsync_pulse();
        chk("t1_fc", 32'(frame_count), 1);
        rxq.delete();
        px(8'd10); px(8'd20); px(8'd30); px(8'd40);
        chk("t1_lat0", 32'(pix_valid), 0);
        px(8'd50);
        chk("t1_lat1", 32'(pix_valid), 0);
        px(8'd60);
        chk("t1_lat2_valid", 32'(pix_valid), 1);
        chk("t1_lat2_data", 32'(pix_data), 25);
        chk("t1_lat2_sof", 32'(pix_sof), 1);
        px(8'd70); px(8'd80);
        cam_href = 1'b0;
        cyc(6);
        chk("t1_count", 32'(rxq.size()), 2);
        chk("t1_px0", 32'(rxq[0]), ent(1, 25));
        chk("t1_px1", 32'(rxq[1]), ent(0, 65));

        // 2: 16 lines of 16 pixels, value = line index
        rxq.delete();
        vsync_pulse();
        chk("t2_fc", 32'(frame_count), 2);
        for (int l = 0; l < 16; l++) begin
            for (int p = 0; p < 16; p++) px(8'(l));
            line_end();
        end
        cyc(6);
        chk("t2_count", 32'(rxq.size()), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_px%0d", i), 32'(rxq[i]), ent((i == 0) ? 1 : 0, (i / 4) * 4));
        end
        chk("t2_ovf", 32'(overflow), 0);

        // 3: stalled consumer, 16 groups into an 8-deep FIFO
        pix_ready = 1'b0;
        vsync_pulse();
        chk("t3_fc", 32'(frame_count), 3);
        rxq.delete();
        for (int i = 0; i < 64; i++) px(8'(i * 4));
        cam_href = 1'b0;
        cyc(4);
        chk("t3_valid", 32'(pix_valid), 1);
        chk("t3_ovf_set", 32'(overflow), 1);
        chk("t3_hold_data", 32'(pix_data), 6);
        chk("t3_hold_sof", 32'(pix_sof), 1);
        vsync_pulse();
        chk("t3_ovf_clr", 32'(overflow), 0);
        chk("t3_fc2", 32'(frame_count), 4);
        pix_ready = 1'b1;
        cyc(12);
        chk("t3_count", 32'(rxq.size()), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_px%0d", i), 32'(rxq[i]), ent((i == 0) ? 1 : 0, i * 16 + 6));
        end

        // 4: full FIFO, single-cycle pop exactly when the 9th group is pushed
        rxq.delete();
        pix_ready = 1'b0;
        vsync_pulse();
        chk("t4_fc", 32'(frame_count), 5);
        for (int i = 0; i < 36; i++) px(8'(i * 4));
        cam_href  = 1'b0;
        pix_ready = 1'b1;
        cyc(1);
        pix_ready = 1'b0;
        cyc(3);
        chk("t4_ovf", 32'(overflow), 0);
        chk("t4_popped", 32'(rxq.size()), 1);
        pix_ready = 1'b1;
        cyc(12);
        chk("t4_count", 32'(rxq.size()), 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t4_px%0d", i), 32'(rxq[i]), ent((i == 0) ? 1 : 0, i * 16 + 6));
        end

        // 5: short line leaves a partial group that must not leak into the next kept line
        rxq.delete();
        vsync_pulse();
        chk("t5_fc", 32'(frame_count), 6);
        px(8'd4); px(8'd8); px(8'd12); px(8'd16); px(8'd20); px(8'd24);
        line_end();
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 4; p++) px(8'd200);
            line_end();
        end
        px(8'd40); px(8'd40); px(8'd40); px(8'd44);
        cam_href = 1'b0;
        cyc(6);
        chk("t5_count", 32'(rxq.size()), 2);
        chk("t5_px0", 32'(rxq[0]), ent(1, 10));
        chk("t5_px1", 32'(rxq[1]), ent(0, 41));

        // 6: reset mid-line with 3 entries queued
        rxq.delete();
        pix_ready = 1'b0;
        vsync_pulse();
        chk("t6_fc", 32'(frame_count), 7);
        for (int i = 0; i < 14; i++) px(8'd8);
        chk("t6_pre_valid", 32'(pix_valid), 1);
        rst_n    = 1'b0;
        cam_data = 8'd8;
        cam_href = 1'b1;
        cyc(1);
        chk("t6_rst_valid", 32'(pix_valid), 0);
        chk("t6_rst_fc", 32'(frame_count), 0);
        chk("t6_rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) px(8'd99);
        cam_href = 1'b0;
        cyc(4);
        chk("t6_ignored", 32'(pix_valid), 0);
        chk("t6_fc_hold", 32'(frame_count), 0);
        pix_ready = 1'b1;
        vsync_pulse();
        chk("t6_fc_after", 32'(frame_count), 1);
        for (int i = 0; i < 4; i++) px(8'd12);
        cam_href = 1'b0;
        cyc(6);
        chk("t6_count", 32'(rxq.size()), 1);
        chk("t6_px0", 32'(rxq[0]), ent(1, 12));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
